// File: rtl/timer_rw_control.sv
// ---------------------------------------------------------------------------
// timer_rw_control
// Bus interface and control-word logic for a three-counter 8253-style timer.
// Decodes CPU strobes, stores per-counter control words, sequences LSB/MSB
// byte loads and reads, handles counter-latch commands and drives the
// registered read bus.
//
// Ports
//   clk        system clock, bus pins sampled on the rising edge
//   reset_n    asynchronous active-low reset
//   cs_n       chip select (active low)
//   rd_n       read strobe (active low)
//   wr_n       write strobe (active low)
//   a          address: 0..2 counter, 3 control word
//   din        write data
//   dout       read data (registered)
//   dout_oe    read data drive enable (registered)
//   cnt_value  live counts, counter i at [i*CNT_W +: CNT_W]
//   ctrl_word  per-counter {RW1,RW0,M2,M1,M0,BCD}, counter i at [i*6 +: 6]
//   cw_load    one-cycle pulse: control word stored for counter i
//   cnt_wr     one-cycle pulse: count byte written to counter i
//   cnt_byte   byte carried with cnt_wr
//   cnt_msb    with cnt_wr: 0 = LSB, 1 = MSB
//   load_done  one-cycle pulse: full initial count written to counter i
// ---------------------------------------------------------------------------
module timer_rw_control #(
    parameter int unsigned NUM_CNT = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cs_n,
    input  logic                     rd_n,
    input  logic                     wr_n,
    input  logic [1:0]               a,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     dout_oe,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_value,
    output logic [NUM_CNT*6-1:0]     ctrl_word,
    output logic [NUM_CNT-1:0]       cw_load,
    output logic [NUM_CNT-1:0]       cnt_wr,
    output logic [7:0]               cnt_byte,
    output logic                     cnt_msb,
    output logic [NUM_CNT-1:0]       load_done
);

    localparam int unsigned CW_W     = 6;
    localparam logic [5:0]  CW_RESET = 6'b110000;
    localparam logic [1:0]  RW_LATCH = 2'b00;
    localparam logic [1:0]  RW_LSB   = 2'b01;
    localparam logic [1:0]  RW_MSB   = 2'b10;
    localparam logic [1:0]  RW_BOTH  = 2'b11;
    localparam logic [1:0]  A_CTRL   = 2'b11;

    // State and registered outputs
    logic [NUM_CNT*CW_W-1:0]         ctrl_word_q, ctrl_word_d;
    logic [NUM_CNT-1:0]              wr_ff_q, wr_ff_d;
    logic [NUM_CNT-1:0]              rd_ff_q, rd_ff_d;
    logic [NUM_CNT-1:0]              latched_q, latched_d;
    logic [NUM_CNT-1:0][CNT_W-1:0]   latch_reg_q, latch_reg_d;
    logic                            wr_hi_q, wr_hi_d;
    logic                            rd_lo_q, rd_lo_d;
    logic [NUM_CNT-1:0]              cw_load_q, cw_load_d;
    logic [NUM_CNT-1:0]              cnt_wr_q, cnt_wr_d;
    logic [NUM_CNT-1:0]              load_done_q, load_done_d;
    logic [7:0]                      cnt_byte_q, cnt_byte_d;
    logic                            cnt_msb_q, cnt_msb_d;
    logic [7:0]                      dout_q, dout_d;
    logic                            dout_oe_q, dout_oe_d;

    logic wr_edge_c;
    logic rd_end_c;
    logic rd_active_c;

    // Byte selected by a counter's RW field and its LSB/MSB flip-flop
    function automatic logic msb_sel(input logic [1:0] rw, input logic ff);
        logic r;
        case (rw)
            RW_LSB:  r = 1'b0;
            RW_MSB:  r = 1'b1;
            RW_BOTH: r = ff;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Strobe qualification. The history flops reset to "inactive" so a strobe
    // already low at reset release cannot produce an edge. A read end is
    // blocked while wr_n is low so a read and a write never complete together.
    assign wr_edge_c   = wr_hi_q & ~wr_n & ~cs_n & rd_n;
    assign rd_end_c    = rd_lo_q & rd_n & ~cs_n & wr_n;
    assign rd_active_c = ~cs_n & ~rd_n & wr_n;

    // Next-state and output logic
    always_comb begin : next_state
        logic [1:0]       rw;
        logic [CNT_W-1:0] src;
        logic             sel;

        rw          = 2'b00;
        src         = '0;
        sel         = 1'b0;
        ctrl_word_d = ctrl_word_q;
        wr_ff_d     = wr_ff_q;
        rd_ff_d     = rd_ff_q;
        latched_d   = latched_q;
        latch_reg_d = latch_reg_q;
        wr_hi_d     = wr_n;
        rd_lo_d     = ~rd_n;
        cw_load_d   = '0;
        cnt_wr_d    = '0;
        load_done_d = '0;
        cnt_byte_d  = cnt_byte_q;
        cnt_msb_d   = cnt_msb_q;
        dout_d      = 8'h00;
        dout_oe_d   = 1'b0;

        // Read bus: live source tracks cnt_value every cycle unless latched
        if (rd_active_c && (a != A_CTRL)) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (a == 2'(i)) begin
                    rw        = ctrl_word_q[i*CW_W+4 +: 2];
                    src       = latched_q[i] ? latch_reg_q[i] : cnt_value[i*CNT_W +: CNT_W];
                    sel       = msb_sel(rw, rd_ff_q[i]);
                    dout_d    = sel ? src[8 +: 8] : src[0 +: 8];
                    dout_oe_d = 1'b1;
                end
            end
        end

        // Write edge: control word / latch command or count byte
        if (wr_edge_c) begin
            if (a == A_CTRL) begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    if (din[7:6] == 2'(i)) begin
                        if (din[5:4] == RW_LATCH) begin
                            if (!latched_q[i]) begin
                                latch_reg_d[i] = cnt_value[i*CNT_W +: CNT_W];
                                latched_d[i]   = 1'b1;
                            end
                        end else begin
                            ctrl_word_d[i*CW_W +: CW_W] = din[5:0];
                            cw_load_d[i]                = 1'b1;
                            wr_ff_d[i]                  = 1'b0;
                            rd_ff_d[i]                  = 1'b0;
                            latched_d[i]                = 1'b0;
                        end
                    end
                end
            end else begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    if (a == 2'(i)) begin
                        rw          = ctrl_word_q[i*CW_W+4 +: 2];
                        sel         = msb_sel(rw, wr_ff_q[i]);
                        cnt_wr_d[i] = 1'b1;
                        cnt_byte_d  = din;
                        cnt_msb_d   = sel;
                        if (rw == RW_BOTH) begin
                            wr_ff_d[i]     = ~wr_ff_q[i];
                            load_done_d[i] = wr_ff_q[i];
                        end else begin
                            load_done_d[i] = 1'b1;
                        end
                    end
                end
            end
        end

        // Read end: advance byte pointer and release the latch
        if (rd_end_c && (a != A_CTRL)) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (a == 2'(i)) begin
                    rw = ctrl_word_q[i*CW_W+4 +: 2];
                    if (rw == RW_BOTH) begin
                        rd_ff_d[i] = ~rd_ff_q[i];
                        if (rd_ff_q[i]) begin
                            latched_d[i] = 1'b0;
                        end
                    end else begin
                        latched_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_word_q <= {NUM_CNT{CW_RESET}};
            wr_ff_q     <= '0;
            rd_ff_q     <= '0;
            latched_q   <= '0;
            latch_reg_q <= '0;
            wr_hi_q     <= 1'b0;
            rd_lo_q     <= 1'b0;
            cw_load_q   <= '0;
            cnt_wr_q    <= '0;
            load_done_q <= '0;
            cnt_byte_q  <= 8'h00;
            cnt_msb_q   <= 1'b0;
            dout_q      <= 8'h00;
            dout_oe_q   <= 1'b0;
        end else begin
            ctrl_word_q <= ctrl_word_d;
            wr_ff_q     <= wr_ff_d;
            rd_ff_q     <= rd_ff_d;
            latched_q   <= latched_d;
            latch_reg_q <= latch_reg_d;
            wr_hi_q     <= wr_hi_d;
            rd_lo_q     <= rd_lo_d;
            cw_load_q   <= cw_load_d;
            cnt_wr_q    <= cnt_wr_d;
            load_done_q <= load_done_d;
            cnt_byte_q  <= cnt_byte_d;
            cnt_msb_q   <= cnt_msb_d;
            dout_q      <= dout_d;
            dout_oe_q   <= dout_oe_d;
        end
    end

    assign ctrl_word = ctrl_word_q;
    assign cw_load   = cw_load_q;
    assign cnt_wr    = cnt_wr_q;
    assign load_done = load_done_q;
    assign cnt_byte  = cnt_byte_q;
    assign cnt_msb   = cnt_msb_q;
    assign dout      = dout_q;
    assign dout_oe   = dout_oe_q;

endmodule

// File: tb/tb_timer_rw_control.sv
// ---------------------------------------------------------------------------
// tb_timer_rw_control
// Directed bus sequences for timer_rw_control. Expected write pulses and read
// bytes are queued when the bus cycle is issued; a negedge monitor pops and
// compares whenever the DUT presents a pulse or starts driving dout.
// ---------------------------------------------------------------------------
module tb_timer_rw_control;

    logic        clk;
    logic        reset_n;
    logic        cs_n;
    logic        rd_n;
    logic        wr_n;
    logic [1:0]  a;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        dout_oe;
    logic [47:0] cnt_value;
    logic [17:0] ctrl_word;
    logic [2:0]  cw_load;
    logic [2:0]  cnt_wr;
    logic [7:0]  cnt_byte;
    logic        cnt_msb;
    logic [2:0]  load_done;

    typedef struct packed {
        logic [2:0] cw;
        logic [2:0] wr;
        logic [2:0] ld;
        logic [7:0] b;
        logic       m;
    } wev_t;

    wev_t       wq[$];
    logic [7:0] rq[$];
    int         total = 0;
    int         bad   = 0;
    logic       prev_oe = 1'b0;

    timer_rw_control dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cs_n      (cs_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .a         (a),
        .din       (din),
        .dout      (dout),
        .dout_oe   (dout_oe),
        .cnt_value (cnt_value),
        .ctrl_word (ctrl_word),
        .cw_load   (cw_load),
        .cnt_wr    (cnt_wr),
        .cnt_byte  (cnt_byte),
        .cnt_msb   (cnt_msb),
        .load_done (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare pulses and first cycle of each read against the queues
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_oe = 1'b0;
        end else begin
            if ((cw_load != 3'b0) || (cnt_wr != 3'b0) || (load_done != 3'b0)) begin
                total++;
                if (wq.size() == 0) begin
                    bad++;
                    $display("FAIL wr_event unexpected: cw_load=%b cnt_wr=%b load_done=%b byte=%h msb=%b",
                             cw_load, cnt_wr, load_done, cnt_byte, cnt_msb);
                end else begin
                    wev_t e;
                    e = wq.pop_front();
                    if ((cw_load != e.cw) || (cnt_wr != e.wr) || (load_done != e.ld) ||
                        ((e.wr != 3'b0) && ((cnt_byte != e.b) || (cnt_msb != e.m)))) begin
                        bad++;
                        $display("FAIL wr_event: got cw=%b wr=%b ld=%b byte=%h msb=%b, want cw=%b wr=%b ld=%b byte=%h msb=%b",
                                 cw_load, cnt_wr, load_done, cnt_byte, cnt_msb,
                                 e.cw, e.wr, e.ld, e.b, e.m);
                    end
                end
            end
            if (dout_oe && !prev_oe) begin
                total++;
                if (rq.size() == 0) begin
                    bad++;
                    $display("FAIL rd_event unexpected: dout=%h", dout);
                end else begin
                    logic [7:0] r;
                    r = rq.pop_front();
                    if (dout !== r) begin
                        bad++;
                        $display("FAIL rd_event: got dout=%h want %h", dout, r);
                    end
                end
            end
            prev_oe = dout_oe;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic exp_w(input logic [2:0] cw, input logic [2:0] wr, input logic [2:0] ld,
                         input logic [7:0] b, input logic m);
        wev_t e;
        e.cw = cw; e.wr = wr; e.ld = ld; e.b = b; e.m = m;
        wq.push_back(e);
    endtask

    task automatic bus_wr(input logic [1:0] addr, input logic [7:0] d);
        @(negedge clk); cs_n = 1'b0; a = addr; din = d; wr_n = 1'b0;
        @(negedge clk); wr_n = 1'b1;
        @(negedge clk); cs_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] addr);
        @(negedge clk); cs_n = 1'b0; a = addr; rd_n = 1'b0;
        @(negedge clk);
        @(negedge clk); rd_n = 1'b1;
        @(negedge clk); cs_n = 1'b1;
    endtask

    task automatic set_cnt(input int i, input logic [15:0] v);
        cnt_value[i*16 +: 16] = v;
    endtask

    initial begin
        cs_n = 1'b0; rd_n = 1'b1; wr_n = 1'b0; a = 2'd0; din = 8'h00;
        cnt_value = '0; reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        // wr_n held low across reset release must not count as a write
        repeat (3) @(negedge clk);
        chk("reset ctrl_word", 32'(ctrl_word), 32'h30C30);
        chk("reset pulses", 32'({cw_load, cnt_wr, load_done}), 32'h0);
        chk("reset dout_oe", 32'(dout_oe), 32'h0);
        chk("reset dout", 32'(dout), 32'h0);
        wr_n = 1'b1; cs_n = 1'b1;
        repeat (2) @(negedge clk);

        // Counter 0 mode 2, LSB then MSB
        exp_w(3'b001, 3'b000, 3'b000, 8'h00, 1'b0); bus_wr(2'd3, 8'h34);
        chk("cw0 stored", 32'(ctrl_word[5:0]), 32'h34);
        exp_w(3'b000, 3'b001, 3'b000, 8'h1E, 1'b0); bus_wr(2'd0, 8'h1E);
        exp_w(3'b000, 3'b001, 3'b001, 8'h00, 1'b1); bus_wr(2'd0, 8'h00);

        // Counter 1 LSB-only, mode 5
        exp_w(3'b010, 3'b000, 3'b000, 8'h00, 1'b0); bus_wr(2'd3, 8'h5A);
        chk("cw1 stored", 32'(ctrl_word[11:6]), 32'h1A);
        exp_w(3'b000, 3'b010, 3'b010, 8'h05, 1'b0); bus_wr(2'd1, 8'h05);
        set_cnt(1, 16'hBEEF);
        rq.push_back(8'hEF); bus_rd(2'd1);
        rq.push_back(8'hEF); bus_rd(2'd1);

        // Counter 2 MSB-only, latched read then live read
        exp_w(3'b100, 3'b000, 3'b000, 8'h00, 1'b0); bus_wr(2'd3, 8'hA0);
        chk("cw2 stored", 32'(ctrl_word[17:12]), 32'h20);
        exp_w(3'b000, 3'b100, 3'b100, 8'h77, 1'b1); bus_wr(2'd2, 8'h77);
        set_cnt(2, 16'h4321);
        bus_wr(2'd3, 8'h80);
        set_cnt(2, 16'h9999);
        rq.push_back(8'h43); bus_rd(2'd2);
        rq.push_back(8'h99); bus_rd(2'd2);

        // Counter 0 latch: latched LSB/MSB, then live bytes
        set_cnt(0, 16'h1234);
        bus_wr(2'd3, 8'h00);
        chk("latch leaves cw0", 32'(ctrl_word[5:0]), 32'h34);
        set_cnt(0, 16'h1200);
        rq.push_back(8'h34); bus_rd(2'd0);
        rq.push_back(8'h12); bus_rd(2'd0);
        rq.push_back(8'h00); bus_rd(2'd0);
        rq.push_back(8'h12); bus_rd(2'd0);

        // Second latch while latched is ignored
        set_cnt(0, 16'hABCD);
        bus_wr(2'd3, 8'h00);
        set_cnt(0, 16'h5566);
        bus_wr(2'd3, 8'h00);
        rq.push_back(8'hCD); bus_rd(2'd0);
        rq.push_back(8'hAB); bus_rd(2'd0);

        // Control word mid-sequence resets both byte pointers
        exp_w(3'b000, 3'b001, 3'b000, 8'h11, 1'b0); bus_wr(2'd0, 8'h11);
        rq.push_back(8'h66); bus_rd(2'd0);
        exp_w(3'b001, 3'b000, 3'b000, 8'h00, 1'b0); bus_wr(2'd3, 8'h34);
        rq.push_back(8'h66); bus_rd(2'd0);
        rq.push_back(8'h55); bus_rd(2'd0);
        exp_w(3'b000, 3'b001, 3'b000, 8'h22, 1'b0); bus_wr(2'd0, 8'h22);
        exp_w(3'b000, 3'b001, 3'b001, 8'h33, 1'b1); bus_wr(2'd0, 8'h33);

        // Reset between LSB and MSB abandons the sequence
        exp_w(3'b000, 3'b001, 3'b000, 8'h44, 1'b0); bus_wr(2'd0, 8'h44);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk);
        chk("mid reset ctrl_word", 32'(ctrl_word), 32'h30C30);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_w(3'b000, 3'b001, 3'b000, 8'h55, 1'b0); bus_wr(2'd0, 8'h55);
        exp_w(3'b000, 3'b001, 3'b001, 8'h66, 1'b1); bus_wr(2'd0, 8'h66);

        // SC=3 ignored
        bus_wr(2'd3, 8'hF4);
        chk("sc3 ctrl_word", 32'(ctrl_word), 32'h30C30);

        // Both strobes low: no write, no drive
        @(negedge clk); cs_n = 1'b0; a = 2'd0; din = 8'hAA; rd_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("both low dout_oe", 32'(dout_oe), 32'h0);
        chk("both low dout", 32'(dout), 32'h0);
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;

        // Read of control address does not drive
        @(negedge clk); cs_n = 1'b0; a = 2'd3; rd_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("read a3 dout_oe", 32'(dout_oe), 32'h0);
        rd_n = 1'b1;
        @(negedge clk); cs_n = 1'b1;

        repeat (5) @(negedge clk);
        chk("wr queue drained", 32'(wq.size()), 32'h0);
        chk("rd queue drained", 32'(rq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
